// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller: states, opcodes,
// func codes, instruction classes and datapath select values.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd7
  } state_t;

  // Branches are split by polarity so the FSM never has to look at OpCode.
  typedef enum logic [3:0] {
    CL_RTYPE,
    CL_ALUI_S,
    CL_ALUI_L,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_BNE,
    CL_J,
    CL_JAL,
    CL_JR,
    CL_HALT,
    CL_ILLEGAL
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_LOGI = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  localparam logic [1:0] PCSRC_PC4 = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;
  localparam logic [1:0] PCSRC_RS  = 2'b11;

endpackage

// File: rtl/mc_main_decoder.sv
// Maps OpCode/func to an instruction class and flags the instructions whose
// signed overflow must block the register write.
module mc_main_decoder
  import mc_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic [5:0]   op_code,
  input  logic [5:0]   func,
  output instr_class_t instr_class,
  output logic         is_ov_checked
);

  always_comb begin
    instr_class   = CL_ILLEGAL;
    is_ov_checked = 1'b0;
    if (op_code == HALT_OP) begin
      instr_class = CL_HALT;
    end else begin
      case (op_code)
        OP_RTYPE: begin
          case (func)
            FN_ADD, FN_SUB: begin
              instr_class   = CL_RTYPE;
              is_ov_checked = 1'b1;
            end
            FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: instr_class = CL_RTYPE;
            FN_JR:   instr_class = CL_JR;
            default: instr_class = CL_ILLEGAL;
          endcase
        end
        OP_ADDI: begin
          instr_class   = CL_ALUI_S;
          is_ov_checked = 1'b1;
        end
        OP_ADDIU:               instr_class = CL_ALUI_S;
        OP_ANDI, OP_ORI, OP_LUI: instr_class = CL_ALUI_L;
        OP_LW:                  instr_class = CL_LW;
        OP_SW:                  instr_class = CL_SW;
        OP_BEQ:                 instr_class = CL_BEQ;
        OP_BNE:                 instr_class = CL_BNE;
        OP_J:                   instr_class = CL_J;
        OP_JAL:                 instr_class = CL_JAL;
        default:                instr_class = CL_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main controller: walks each instruction through
// IF/ID/EX/MEM/WB and drives datapath enables, selects and ALU controls.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter logic [4:0] RA_IDX  = 5'd31,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       overflow,
  output logic       PCWr,
  output logic       IRWr,
  output logic       MemWr,
  output logic       RegWr,
  output logic       ALUSrc,
  output logic [1:0] ALUop,
  output logic       ExtOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] PCSrc,
  output logic [2:0] state
);

  // state   | meaning
  // IF   0  | fetch: load IR, PC <= PC+4
  // ID   1  | decode; j/jal complete here, illegal ops retire as nop
  // EX   2  | ALU operation; branches and jr complete here
  // MEM  3  | data memory access for lw/sw
  // WB   4  | register write-back, blocked when ov_q is set
  // HALT 7  | parked until reset

  state_t       state_q, state_d;
  instr_class_t cls;
  logic         ov_chk;
  logic         ov_q;

  // RegDst=10 selects this index inside the datapath; zero would alias $zero.
  if (RA_IDX == 5'd0) begin : g_ra_idx_check
    $error("RA_IDX must not be register 0");
  end

  mc_main_decoder #(.HALT_OP(HALT_OP)) u_dec (
    .op_code       (OpCode),
    .func          (func),
    .instr_class   (cls),
    .is_ov_checked (ov_chk)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IF;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 ov_q <= 1'b0;
    else if (state_q == ST_IF) ov_q <= 1'b0;
    else if (state_q == ST_EX) ov_q <= overflow & ov_chk;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IF: state_d = ST_ID;
      ST_ID: begin
        case (cls)
          CL_J, CL_JAL, CL_ILLEGAL: state_d = ST_IF;
          CL_HALT:                  state_d = ST_HALT;
          default:                  state_d = ST_EX;
        endcase
      end
      ST_EX: begin
        case (cls)
          CL_BEQ, CL_BNE, CL_JR: state_d = ST_IF;
          CL_LW, CL_SW:          state_d = ST_MEM;
          default:               state_d = ST_WB;
        endcase
      end
      ST_MEM:  state_d = (cls == CL_LW) ? ST_WB : ST_IF;
      ST_WB:   state_d = ST_IF;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IF;
    endcase
  end

  always_comb begin
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    MemWr    = 1'b0;
    RegWr    = 1'b0;
    ALUSrc   = 1'b0;
    ALUop    = ALUOP_ADD;
    ExtOp    = 1'b0;
    RegDst   = REGDST_RT;
    MemtoReg = M2R_ALU;
    PCSrc    = PCSRC_PC4;
    if (!reset) begin
      // ALU controls hold from EX through WB so the result stays stable.
      if (state_q inside {ST_EX, ST_MEM, ST_WB}) begin
        case (cls)
          CL_LW, CL_SW, CL_ALUI_S: begin
            ALUSrc = 1'b1;
            ExtOp  = 1'b1;
          end
          CL_ALUI_L: begin
            ALUSrc = 1'b1;
            ALUop  = ALUOP_LOGI;
          end
          CL_RTYPE:       ALUop = ALUOP_FUNC;
          CL_BEQ, CL_BNE: ALUop = ALUOP_SUB;
          default: ;
        endcase
      end
      case (state_q)
        ST_IF: begin
          PCWr = 1'b1;
          IRWr = 1'b1;
        end
        ST_ID: begin
          if (cls == CL_J || cls == CL_JAL) begin
            PCWr  = 1'b1;
            PCSrc = PCSRC_J;
          end
          if (cls == CL_JAL) begin
            RegWr    = 1'b1;
            RegDst   = REGDST_RA;
            MemtoReg = M2R_PC4;
          end
        end
        ST_EX: begin
          case (cls)
            CL_BEQ: begin
              PCSrc = PCSRC_BR;
              PCWr  = zero;
            end
            CL_BNE: begin
              PCSrc = PCSRC_BR;
              PCWr  = ~zero;
            end
            CL_JR: begin
              PCSrc = PCSRC_RS;
              PCWr  = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: MemWr = (cls == CL_SW);
        ST_WB: begin
          RegWr    = ~ov_q;
          RegDst   = (cls == CL_RTYPE) ? REGDST_RD : REGDST_RT;
          MemtoReg = (cls == CL_LW) ? M2R_MEM : M2R_ALU;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized scoreboard bench for mc_control_fsm: every cycle's expected
// outputs come from a per-instruction reference model and are checked by a monitor.
module tb_mc_control_fsm;

  localparam logic [5:0] HALT_OP = 6'b111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode, func;
  logic       zero, overflow;
  logic       PCWr, IRWr, MemWr, RegWr, ALUSrc, ExtOp;
  logic [1:0] ALUop, RegDst, MemtoReg, PCSrc;
  logic [2:0] state;

  always #5 clk = ~clk;

  mc_control_fsm #(.RA_IDX(5'd31), .HALT_OP(HALT_OP)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .func(func), .zero(zero),
    .overflow(overflow), .PCWr(PCWr), .IRWr(IRWr), .MemWr(MemWr), .RegWr(RegWr),
    .ALUSrc(ALUSrc), .ALUop(ALUop), .ExtOp(ExtOp), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .PCSrc(PCSrc), .state(state)
  );

  typedef struct packed {
    logic       pcwr, irwr, memwr, regwr, alusrc;
    logic [1:0] aluop;
    logic       extop;
    logic [1:0] regdst, memtoreg, pcsrc;
    logic [2:0] st;
  } obs_t;

  typedef enum int {
    K_ADD, K_ADDU, K_SUB, K_SUBU, K_AND, K_OR, K_SLT, K_JR,
    K_ADDI, K_ADDIU, K_ANDI, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_BNE,
    K_J, K_JAL, K_ILL, K_NKIND
  } kind_e;

  obs_t act;
  assign act = {PCWr, IRWr, MemWr, RegWr, ALUSrc, ALUop, ExtOp, RegDst, MemtoReg, PCSrc, state};

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic bit supported(logic [5:0] op, logic [5:0] fn);
    if (op == 6'h00) return fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h08};
    return op inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0f,
                      6'h23, 6'h2b, HALT_OP};
  endfunction

  function automatic logic [11:0] encode(kind_e k);
    logic [5:0] op, fn;
    fn = 6'($urandom);
    case (k)
      K_ADD:   begin op = 6'h00; fn = 6'h20; end
      K_ADDU:  begin op = 6'h00; fn = 6'h21; end
      K_SUB:   begin op = 6'h00; fn = 6'h22; end
      K_SUBU:  begin op = 6'h00; fn = 6'h23; end
      K_AND:   begin op = 6'h00; fn = 6'h24; end
      K_OR:    begin op = 6'h00; fn = 6'h25; end
      K_SLT:   begin op = 6'h00; fn = 6'h2a; end
      K_JR:    begin op = 6'h00; fn = 6'h08; end
      K_ADDI:  op = 6'h08;
      K_ADDIU: op = 6'h09;
      K_ANDI:  op = 6'h0c;
      K_ORI:   op = 6'h0d;
      K_LUI:   op = 6'h0f;
      K_LW:    op = 6'h23;
      K_SW:    op = 6'h2b;
      K_BEQ:   op = 6'h04;
      K_BNE:   op = 6'h05;
      K_J:     op = 6'h02;
      K_JAL:   op = 6'h03;
      default: begin
        do begin
          op = 6'($urandom);
          fn = 6'($urandom);
        end while (supported(op, fn));
      end
    endcase
    return {op, fn};
  endfunction

  function automatic bit is_r_alu(kind_e k);
    return k inside {K_ADD, K_ADDU, K_SUB, K_SUBU, K_AND, K_OR, K_SLT};
  endfunction

  // Cycle count per instruction, and which step each cycle is.
  function automatic int n_cycles(kind_e k);
    case (k)
      K_J, K_JAL, K_ILL: return 2;
      K_BEQ, K_BNE, K_JR: return 3;
      K_LW: return 5;
      default: return 4;
    endcase
  endfunction

  function automatic logic [2:0] step_state(kind_e k, int i);
    if (i < 3) return 3'(i);
    if (k == K_LW) return (i == 3) ? 3'd3 : 3'd4;
    if (k == K_SW) return 3'd3;
    return 3'd4;
  endfunction

  function automatic obs_t expect_out(kind_e k, logic [2:0] st, logic z, logic ov_blocked);
    obs_t e;
    e = '0;
    e.st = st;
    if (st == 3'd0) begin
      e.pcwr = 1; e.irwr = 1;
    end else if (st == 3'd1) begin
      if (k == K_J || k == K_JAL) begin e.pcwr = 1; e.pcsrc = 2'b10; end
      if (k == K_JAL) begin e.regwr = 1; e.regdst = 2'b10; e.memtoreg = 2'b10; end
    end else begin
      if (k inside {K_LW, K_SW, K_ADDI, K_ADDIU}) begin e.alusrc = 1; e.extop = 1; end
      if (k inside {K_ANDI, K_ORI, K_LUI}) begin e.alusrc = 1; e.aluop = 2'b11; end
      if (is_r_alu(k)) e.aluop = 2'b10;
      if (k == K_BEQ || k == K_BNE) e.aluop = 2'b01;
      if (st == 3'd2 && (k == K_BEQ || k == K_BNE)) begin
        e.pcsrc = 2'b01;
        e.pcwr  = (k == K_BEQ) ? z : ~z;
      end
      if (st == 3'd2 && k == K_JR) begin e.pcwr = 1; e.pcsrc = 2'b11; end
      if (st == 3'd3 && k == K_SW) e.memwr = 1;
      if (st == 3'd4) begin
        e.regwr    = ~ov_blocked;
        e.regdst   = is_r_alu(k) ? 2'b01 : 2'b00;
        e.memtoreg = (k == K_LW) ? 2'b01 : 2'b00;
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, a, e);
    end
  endtask

  // Called at posedge+1 of the instruction's IF cycle; returns at posedge+1 of
  // the cycle after it, or at the WB cycle (inputs driven, nothing queued) if stop_wb.
  task automatic run_core(input kind_e k, input logic [5:0] op, input logic [5:0] fn,
                          input int zf, input int of, input bit stop_wb);
    logic ov_blocked;
    ov_blocked = 1'b0;
    for (int i = 0; i < n_cycles(k); i++) begin
      logic       z, o;
      logic [2:0] st;
      st = step_state(k, i);
      z  = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
      o  = (of < 0) ? 1'($urandom_range(0, 1)) : 1'(of);
      if (i == 0) begin
        OpCode = 6'($urandom);
        func   = 6'($urandom);
      end else begin
        OpCode = op;
        func   = fn;
      end
      zero     = z;
      overflow = o;
      if (st == 3'd2) ov_blocked = o & (k inside {K_ADD, K_SUB, K_ADDI});
      if (stop_wb && st == 3'd4) return;
      exp_q.push_back(expect_out(k, st, z, ov_blocked));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input kind_e k, input int zf, input int of);
    logic [11:0] enc;
    enc = encode(k);
    run_core(k, enc[11:6], enc[5:0], zf, of, 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t state=%0d actual=%h required=%h", $time, state, act, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    obs_t e;
    kind_e k;
    reset = 1; OpCode = '0; func = '0; zero = 0; overflow = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outputs", 32'(act), 32'd0);
    reset = 0;

    run_instr(K_ADD, -1, 0);
    run_instr(K_LW, -1, -1);
    run_instr(K_BEQ, 1, -1);
    run_instr(K_BEQ, 0, -1);
    run_instr(K_BNE, 1, -1);
    run_instr(K_BNE, 0, -1);
    run_instr(K_ADDI, -1, 1);
    run_instr(K_ADDU, -1, 1);
    run_instr(K_SUB, -1, 1);
    run_instr(K_JAL, -1, -1);
    run_instr(K_J, -1, -1);
    run_instr(K_JR, -1, -1);
    run_instr(K_SW, -1, -1);
    run_core(K_ILL, 6'b010000, 6'h00, -1, -1, 1'b0);
    run_core(K_ILL, 6'h00, 6'h3f, -1, -1, 1'b0);

    repeat (300) begin
      k = kind_e'($urandom_range(0, int'(K_NKIND) - 1));
      run_instr(k, -1, -1);
    end

    // Reset in the middle of an R-type write-back.
    run_core(K_ADD, 6'h00, 6'h20, -1, 0, 1'b1);
    #1;
    chk("wb_regwr_pre_reset", 32'(RegWr), 32'd1);
    reset = 1;
    #1;
    chk("reset_wb_regwr", 32'(RegWr), 32'd0);
    chk("reset_wb_state", 32'(state), 32'd0);
    chk("reset_wb_outputs", 32'(act), 32'd0);
    @(posedge clk);
    #1;
    chk("reset_hold_outputs", 32'(act), 32'd0);
    reset = 0;
    run_instr(K_SW, -1, -1);
    run_instr(K_ANDI, -1, -1);

    // HALT parks the FSM regardless of later OpCodes.
    OpCode = 6'($urandom); func = 6'($urandom);
    e = '0; e.pcwr = 1; e.irwr = 1; e.st = 3'd0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    OpCode = HALT_OP;
    e = '0; e.st = 3'd1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    repeat (20) begin
      OpCode = 6'($urandom); func = 6'($urandom);
      zero = 1'($urandom_range(0, 1)); overflow = 1'($urandom_range(0, 1));
      e = '0; e.st = 3'd7;
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    reset = 1;
    #1;
    chk("halt_reset_state", 32'(state), 32'd0);
    chk("halt_reset_outputs", 32'(act), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    run_instr(K_ADD, -1, 0);
    run_instr(K_LW, -1, -1);

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
